// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit slice per stage, valid/ready backpressure.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic             io_in_sub,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_s,
  output logic             io_out_c
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             io_out_ovf
`endif
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % CHUNK) != 0 || STAGES < 1) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             valid_reg [STAGES];
  logic             carry_reg [STAGES];
  logic [WIDTH-1:0] s_reg     [STAGES];
  logic [WIDTH-1:0] a_reg     [STAGES];
  logic [WIDTH-1:0] b_reg     [STAGES];

  logic             ready      [STAGES];
  logic             valid_in   [STAGES];
  logic             carry_in   [STAGES];
  logic [WIDTH-1:0] a_in       [STAGES];
  logic [WIDTH-1:0] b_in       [STAGES];
  logic [WIDTH-1:0] s_in       [STAGES];
  logic [WIDTH-1:0] s_next     [STAGES];
  logic [CHUNK:0]   chunk_sum  [STAGES];

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      // Unrolled form of ready_k = !valid_k | ready_{k+1}: ready unless every stage from k on is full.
      ready[k] = io_out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!valid_reg[j]) ready[k] = 1'b1;
      end
    end

    valid_in[0] = io_in_valid;
    carry_in[0] = io_in_sub;
    a_in[0]     = io_in_a;
    b_in[0]     = io_in_sub ? ~io_in_b : io_in_b;
    s_in[0]     = '0;
    for (int k = 1; k < STAGES; k++) begin
      valid_in[k] = valid_reg[k-1];
      carry_in[k] = carry_reg[k-1];
      a_in[k]     = a_reg[k-1];
      b_in[k]     = b_reg[k-1];
      s_in[k]     = s_reg[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      chunk_sum[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                   + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_in[k]};
      s_next[k] = s_in[k];
      s_next[k][k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        carry_reg[k] <= 1'b0;
        s_reg[k]     <= '0;
        a_reg[k]     <= '0;
        b_reg[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_reg[k] <= valid_in[k];
          // Data only moves with a real operation so a stalled result never changes.
          if (valid_in[k]) begin
            carry_reg[k] <= chunk_sum[k][CHUNK];
            s_reg[k]     <= s_next[k];
            a_reg[k]     <= a_in[k];
            b_reg[k]     <= b_in[k];
          end
        end
      end
    end
  end

`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_reg;
  logic msb_carry_in;

  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  assign msb_carry_in = chunk_sum[LAST][CHUNK-1] ^ a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_reg <= 1'b0;
    end else if (ready[LAST] && valid_in[LAST]) begin
      ovf_reg <= msb_carry_in ^ chunk_sum[LAST][CHUNK];
    end
  end

  assign io_out_ovf = ovf_reg;
`endif

  assign io_in_ready  = ready[0];
  assign io_out_valid = valid_reg[LAST];
  assign io_out_s     = s_reg[LAST];
  assign io_out_c     = carry_reg[LAST];

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's single-cycle 24-bit full adder.
- Splits a WIDTH-bit add/subtract into CHUNK-bit slices, one slice per pipeline stage, with ripple carry registered between stages.
- Uses a valid/ready handshake with backpressure, so it can sit in the sincos datapath and close timing at widths the combinational adder cannot.

Parameters:
- WIDTH, 24, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per stage; STAGES = WIDTH/CHUNK, with STAGES >= 1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- io_in_valid  input  1  operands valid
- io_in_ready  output  1  block can accept an operation this cycle
- io_in_a  input  WIDTH  operand A
- io_in_b  input  WIDTH  operand B
- io_in_sub  input  1  0: A+B; 1: A-B
- io_out_valid  output  1  result valid
- io_out_ready  input  1  downstream accepts result
- io_out_s  output  WIDTH  sum/difference, modulo 2^WIDTH
- io_out_c  output  1  carry out of MSB; for subtract, 1 = no borrow

Behaviour:
- Interface (already decided): one clock, named clock; reset is synchronous and active-high, named reset.
- Stage k (0..STAGES-1) computes bits [k*CHUNK+CHUNK-1 : k*CHUNK] of the result.
  - It uses the chunk-k bits of A and B', plus the carry registered by stage k-1.
  - Stage 0 carry-in = io_in_sub.
- B' = io_in_b when io_in_sub=0, ~io_in_b when io_in_sub=1.
- Each stage register holds:
  - valid bit
  - carry out of its chunk
  - result bits already computed (low chunks)
  - unconsumed upper A/B' bits
- Upper operand bits shift along with the operation; no skew buffers are needed outside the pipe.
- Latency: exactly STAGES cycles from the accepting edge (io_in_valid & io_in_ready) to io_out_valid=1 for that operation, when unstalled.
- Throughput: 1 operation/cycle when io_out_ready is held 1.
- Handshake:
  - Per stage, ready_k = !valid_k | ready_{k+1}; the last stage's ready = io_out_ready.
  - io_in_ready = ready_0. Bubbles collapse.
  - Transfer at the output occurs on io_out_valid & io_out_ready.
  - While io_out_valid=1 and io_out_ready=0, io_out_s and io_out_c hold stable.
  - Ordering is strict FIFO; no operation is dropped or duplicated.
- Reset: all valid bits cleared, so io_out_valid=0 and io_in_ready=1 on the first cycle after reset.
  - Data registers clear to 0, so io_out_s=0 and io_out_c=0.
  - Reset asserted mid-operation discards every in-flight operation; nothing emerges afterwards.
- STAGES=1: degenerates to a single registered add with the same handshake.
- Inputs sampled only on an accepting edge; io_in_a/b/sub are don't-care otherwise.

Optional Feature:
- Macro: PIPELINED_ADDER_OVF_EN.
- Defined:
  - Adds output io_out_ovf (1 bit), the signed two's-complement overflow of the operation.
  - io_out_ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
  - Reset value 0; held stable under stall like io_out_s.
- Not defined: port absent; no extra logic.

Test Plan:
- WIDTH=24, CHUNK=8: add a=0xFFFFFF, b=0x000001, io_out_ready=1 -> exactly 3 cycles later io_out_valid=1, io_out_s=0x000000, io_out_c=1 (carry ripples across all chunks).
- sub a=0x000005, b=0x000007 -> io_out_s=0xFFFFFE, io_out_c=0; sub a=0x000007, b=0x000005 -> io_out_s=0x000002, io_out_c=1.
- Back-to-back stream of 10 random add/sub ops with io_out_ready=1 -> 10 consecutive valid outputs, one per cycle, each matching the reference model (a ± b) mod 2^24 with correct carry.
- Backpressure: io_out_ready=0, offer 4 ops -> exactly 3 accepted, io_in_ready=0 thereafter, io_out_s stable.
  - Then release io_out_ready -> results emerge in order and the 4th op is accepted on the next cycle.
- Reset pulse with 2 ops in flight -> next cycle io_out_valid=0 and io_in_ready=1; no stale result ever appears.
- With PIPELINED_ADDER_OVF_EN: add 0x7FFFFF+0x000001 -> io_out_ovf=1; sub 0x800000-0x000001 -> io_out_ovf=1; add 0x000001+0x000001 -> io_out_ovf=0.
